// File: rtl/ula_pkg.sv
// Shared types and constants for the sequential ALU: opcode and state
// encodings plus bit positions inside the packed status-flag vector.
package ula_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_NEG   = 3;
  localparam int FLAG_DIV0  = 4;
  localparam int FLAG_W     = 5;

endpackage

// File: rtl/ula_iter_muldiv.sv
// Iterative datapath: unsigned shift-add multiply or restoring divide,
// one step per clock; lo/hi show the values the current step produces.
module ula_iter_muldiv #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             last
);

  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_opnd;
  logic             r_mode;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;

  // Multiply keeps {hi,lo} as the partial product with the multiplier in lo;
  // divide keeps the remainder in hi and shifts the dividend out of lo.
  always_comb begin
    w_addend = r_lo[0] ? r_opnd : '0;
    w_add    = {1'b0, r_hi} + {1'b0, w_addend};
    w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    w_trial  = w_rem_sh - {1'b0, r_opnd};
    lo       = r_lo;
    hi       = r_hi;
    if (!r_mode) begin
      lo = {w_add[0], r_lo[WIDTH-1:1]};
      hi = w_add[WIDTH:1];
    end else if (!w_trial[WIDTH]) begin
      lo = {r_lo[WIDTH-2:0], 1'b1};
      hi = w_trial[WIDTH-1:0];
    end else begin
      lo = {r_lo[WIDTH-2:0], 1'b0};
      hi = w_rem_sh[WIDTH-1:0];
    end
  end

  assign last = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo   <= '0;
      r_hi   <= '0;
      r_opnd <= '0;
      r_mode <= 1'b0;
      r_cnt  <= '0;
    end else if (load) begin
      r_lo   <= mode ? a : b;
      r_hi   <= '0;
      r_opnd <= mode ? b : a;
      r_mode <= mode;
      r_cnt  <= CNT_W'(WIDTH);
    end else if (r_cnt != '0) begin
      r_lo  <= lo;
      r_hi  <= hi;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ula_seq_param.sv
// Sequential ALU top: start/busy/done handshake, single-cycle arithmetic and
// logic ops, and sequencing of the iterative multiply/divide unit.
module ula_seq_param
  import ula_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado_ula,
  output logic [WIDTH-1:0] resultado_alto,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_neg,
  output logic             flag_div0
);

  localparam int MSB = WIDTH - 1;

  state_e r_state;
  state_e w_state_nxt;
  op_e    r_op;
  op_e    w_op;

  logic [WIDTH-1:0]  r_res;
  logic [WIDTH-1:0]  r_alto;
  logic [FLAG_W-1:0] r_flags;
  logic              r_done;

  logic              w_multi;
  logic              w_load;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH:0]    w_diff;
  logic [WIDTH-1:0]  w_res;
  logic [WIDTH-1:0]  w_alto;
  logic [FLAG_W-1:0] w_flags;
  logic [FLAG_W-1:0] w_calc_flags;
  logic [WIDTH-1:0]  w_lo;
  logic [WIDTH-1:0]  w_hi;
  logic              w_last;

  assign w_op    = op_e'(sel_op);
  assign w_multi = (w_op == OP_MUL) || ((w_op == OP_DIV) && (b != '0));
  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign w_diff  = {1'b0, a} - {1'b0, b};

  ula_iter_muldiv #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_iter (
    .clk (clk),
    .rst (rst),
    .load(w_load),
    .mode(w_op == OP_DIV),
    .a   (a),
    .b   (b),
    .lo  (w_lo),
    .hi  (w_hi),
    .last(w_last)
  );

  // Divide by zero lands here too: it completes in one cycle with a saturated quotient.
  always_comb begin
    w_res   = '0;
    w_alto  = '0;
    w_flags = '0;
    case (w_op)
      OP_ADD: begin
        w_res               = w_sum[WIDTH-1:0];
        w_flags[FLAG_CARRY] = w_sum[WIDTH];
        w_flags[FLAG_OVF]   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_res               = w_diff[WIDTH-1:0];
        w_flags[FLAG_CARRY] = w_diff[WIDTH];
        w_flags[FLAG_OVF]   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_DIV: begin
        w_res              = '1;
        w_alto             = a;
        w_flags[FLAG_DIV0] = 1'b1;
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NOT:  w_res = ~a;
      default: w_res = '0;
    endcase
    w_flags[FLAG_ZERO] = (w_res == '0);
    w_flags[FLAG_NEG]  = w_res[MSB];
  end

  always_comb begin
    w_calc_flags            = '0;
    w_calc_flags[FLAG_ZERO] = (w_lo == '0);
    w_calc_flags[FLAG_NEG]  = w_lo[MSB];
    w_calc_flags[FLAG_OVF]  = (r_op == OP_MUL) && (w_hi != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && w_multi) begin
          w_state_nxt = ST_CALC;
          w_load      = 1'b1;
        end
      end
      ST_CALC: begin
        if (w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= OP_ADD;
      r_res   <= '0;
      r_alto  <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == ST_IDLE) && start) begin
        r_op <= w_op;
        if (!w_multi) begin
          r_res   <= w_res;
          r_alto  <= w_alto;
          r_flags <= w_flags;
          r_done  <= 1'b1;
        end
      end else if ((r_state == ST_CALC) && w_last) begin
        r_res   <= w_lo;
        r_alto  <= w_hi;
        r_flags <= w_calc_flags;
        r_done  <= 1'b1;
      end
    end
  end

  assign busy           = (r_state == ST_CALC);
  assign done           = r_done;
  assign resultado_ula  = r_res;
  assign resultado_alto = r_alto;
  assign flag_zero      = r_flags[FLAG_ZERO];
  assign flag_carry     = r_flags[FLAG_CARRY];
  assign flag_ovf       = r_flags[FLAG_OVF];
  assign flag_neg       = r_flags[FLAG_NEG];
  assign flag_div0      = r_flags[FLAG_DIV0];

endmodule

// File: doc/ula_seq_param.md
Name: ula_seq_param

Overview:
Parametrised sequential ALU, the next-generation arithmetic unit of the datapath. It registers operands on a start/busy/done handshake. Single-cycle operations are add, sub, AND, OR, XOR and NOT. Multi-cycle operations are multiply (shift-add) and divide (restoring). It produces a double-width result (high half = product MSBs or remainder) plus a status flag set.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 4..32)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A (unsigned for mult/div)
b  input  WIDTH  operand B
sel_op  input  3  000 add, 001 sub, 010 mult, 011 div, 100 AND, 101 OR, 110 XOR, 111 NOT(a)
busy  output  1  operation in progress
done  output  1  one-cycle pulse, result/flags valid
resultado_ula  output  WIDTH  result / product low half / quotient
resultado_alto  output  WIDTH  product high half / remainder; 0 for other ops
flag_zero  output  1  resultado_ula == 0
flag_carry  output  1  add: carry-out; sub: borrow (a<b); else 0
flag_ovf  output  1  add/sub: signed overflow; mult: resultado_alto != 0; else 0
flag_neg  output  1  resultado_ula[WIDTH-1]
flag_div0  output  1  div with b == 0

Behaviour:
- Reset (async, any time, including mid-operation): state IDLE; all outputs 0; internal operand, accumulator and counter registers cleared. Any in-flight operation is aborted, with no done pulse.
- States: IDLE, CALC.
- IDLE + start at edge E:
  - a, b, sel_op captured.
  - Add/sub/logic/NOT: result and flags registered at E; done=1 for the cycle after E; busy stays 0.
  - Mult/div with b != 0: go to CALC at E; busy=1; counter=WIDTH.
  - Div with b == 0: no CALC. At E: resultado_ula = all ones, resultado_alto = a, flag_div0=1, flag_zero=0, flag_neg=1; done pulses.
- CALC:
  - One iteration per edge. Counter decrements.
  - At the WIDTH-th CALC edge: final result and flags registered, done=1, busy=0, state IDLE.
  - done is high exactly WIDTH+1 edges after the start edge.
- Mult: unsigned shift-add, 2*WIDTH product; {resultado_alto, resultado_ula} = a*b.
- Div: unsigned restoring, one quotient bit per iteration, MSB first; quotient → resultado_ula, remainder → resultado_alto.
- Add/sub: WIDTH+1-bit internal sum. Result = low WIDTH bits (wrap-around modulo 2^WIDTH).
- start while busy=1 is ignored, and the in-flight operands are unaffected.
- start in the same cycle done is high (busy=0) is accepted: back-to-back with zero bubble.
- Outputs and flags hold their last values between done pulses. done never exceeds 1 cycle.
- Operand inputs may change after the start edge without affecting the result.
- Flags not defined for an op are driven 0.

Decomposition:
- Package ula_pkg holds:
  - typedef enum for sel_op codes (OP_ADD..OP_NOT)
  - state enum (ST_IDLE, ST_CALC)
  - localparam helpers for flag bit positions
- One sub-module: ula_iter_muldiv. It contains the iterative shift-add/restoring-divide datapath with its own counter and inputs load/mode/a/b. It outputs lo, hi, last.
- The top holds the FSM, combinational single-cycle ops, flag logic and output registers.

Test Plan (WIDTH=8):
- add 200+100; then add 100+100 → first: resultado_ula=44, flag_carry=1, flag_ovf=0. Second: 200, flag_ovf=1, flag_neg=1. Each done 1 edge after start; busy never high.
- sub 50−100 → resultado_ula=206, flag_carry=1 (borrow), flag_neg=1, flag_zero=0. sub 7−7 → 0, flag_zero=1.
- mult 25*12 → busy high 8 cycles; done at edge 9. resultado_ula=44, resultado_alto=1, flag_ovf=1. mult 255*255 → 1 / 254.
- div 200/7 → done at edge 9, quotient 28, remainder 4. div 5/0 → done at edge 1, resultado_ula=255, resultado_alto=5, flag_div0=1.
- Back-to-back and ignored start:
  - start mult 3*4; pulse start with div at cycle 4 → ignored; result 12.
  - start issued on the done cycle → accepted, completes normally.
- Reset mid-operation: assert rst at cycle 4 of mult 25*12 → outputs 0 immediately (async), busy=0, no done. Next add 1+1 → 2 after 1 edge.
